// File: rtl/bch_syndrome_queue.sv
// Circular queue of finished BCH syndrome sets feeding the sigma solver.
// Each entry carries the syndromes, an errors-present flag and a wrapping codeword tag.
module bch_syndrome_queue #(
  parameter int SW         = 8,
  parameter int DEPTH      = 2,
  parameter int TAG_W      = 4,
  parameter bit SKIP_CLEAN = 1'b0
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             syn_done_i,
  input  logic [SW-1:0]    syndromes_i,
  output logic             syn_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [SW-1:0]    out_syndromes_o,
  output logic             out_errors_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             clean_valid_o,
  output logic [TAG_W-1:0] clean_tag_o,
  output logic [2:0]       level_o,
  output logic             overflow_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [SW-1:0]    syn;
    logic             err;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]       level_q, level_d;
  logic [TAG_W-1:0] tag_q, clean_tag_q, clean_tag_d;
  logic             out_valid_q, syn_ready_q, overflow_q, overflow_d, clean_valid_q;
  logic             err, skip, pop, push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign err  = |syndromes_i;
  assign skip = syn_done_i && SKIP_CLEAN && !err;
  assign pop  = out_valid_q && out_ready_i;
  // A full queue still takes a write when the head leaves in the same cycle.
  assign push = syn_done_i && !skip && ((level_q < 3'(DEPTH)) || pop);

  always_comb begin
    wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    level_d     = level_q + 3'(push) - 3'(pop);
    overflow_d  = overflow_q || (syn_done_i && !skip && !push);
    clean_tag_d = skip ? tag_q : clean_tag_q;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      tag_q         <= '0;
      out_valid_q   <= 1'b0;
      syn_ready_q   <= 1'b1;
      overflow_q    <= 1'b0;
      clean_valid_q <= 1'b0;
      clean_tag_q   <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      if (syn_done_i) tag_q <= tag_q + TAG_W'(1);
      out_valid_q   <= (level_d != 3'd0);
      syn_ready_q   <= (level_d < 3'(DEPTH));
      overflow_q    <= overflow_d;
      clean_valid_q <= skip;
      clean_tag_q   <= clean_tag_d;
    end
  end

  // Entry storage is intentionally not reset; out_* data is ignored while out_valid_o is low.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= '{syn: syndromes_i, err: err, tag: tag_q};
  end

  assign syn_ready_o     = syn_ready_q;
  assign out_valid_o     = out_valid_q;
  assign out_syndromes_o = mem_q[rd_ptr_q].syn;
  assign out_errors_o    = mem_q[rd_ptr_q].err;
  assign out_tag_o       = mem_q[rd_ptr_q].tag;
  assign clean_valid_o   = clean_valid_q;
  assign clean_tag_o     = clean_tag_q;
  assign level_o         = level_q;
  assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_bch_syndrome_queue.sv
// Randomized bench: two queues (clean-skip off / on) share stimulus and are each compared
// against a queue-based reference model every cycle.
module tb_bch_syndrome_queue;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       syn_done = 1'b0;
  logic [7:0] syndromes = '0;
  logic       out_ready = 1'b0;

  logic [1:0] sr, ov, oe, cv, ovf;
  logic [7:0] osyn [2];
  logic [3:0] otag [2];
  logic [3:0] ctag [2];
  logic [2:0] lvl  [2];

  int n_chk = 0;
  int n_err = 0;

  // Reference model: one queue of {tag, syndromes} per instance.
  int mq [2][$];
  int m_tag [2];
  bit m_ovf [2];
  bit m_cv  [2];
  int m_ct  [2];

  always #5 clk = ~clk;

  bch_syndrome_queue #(.SW(8), .DEPTH(DEPTH), .TAG_W(4), .SKIP_CLEAN(1'b0)) u_dut0 (
    .clk_i(clk), .reset_n_i(reset_n), .syn_done_i(syn_done), .syndromes_i(syndromes),
    .syn_ready_o(sr[0]), .out_valid_o(ov[0]), .out_ready_i(out_ready),
    .out_syndromes_o(osyn[0]), .out_errors_o(oe[0]), .out_tag_o(otag[0]),
    .clean_valid_o(cv[0]), .clean_tag_o(ctag[0]), .level_o(lvl[0]), .overflow_o(ovf[0]));

  bch_syndrome_queue #(.SW(8), .DEPTH(DEPTH), .TAG_W(4), .SKIP_CLEAN(1'b1)) u_dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .syn_done_i(syn_done), .syndromes_i(syndromes),
    .syn_ready_o(sr[1]), .out_valid_o(ov[1]), .out_ready_i(out_ready),
    .out_syndromes_o(osyn[1]), .out_errors_o(oe[1]), .out_tag_o(otag[1]),
    .clean_valid_o(cv[1]), .clean_tag_o(ctag[1]), .level_o(lvl[1]), .overflow_o(ovf[1]));

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      m_tag[k] = 0;
      m_ovf[k] = 0;
      m_cv[k]  = 0;
      m_ct[k]  = 0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int sz;
      sz = mq[k].size();
      chk($sformatf("k%0d out_valid", k), ov[k], (sz != 0) ? 1 : 0);
      chk($sformatf("k%0d level", k), lvl[k], sz);
      chk($sformatf("k%0d syn_ready", k), sr[k], (sz < DEPTH) ? 1 : 0);
      chk($sformatf("k%0d overflow", k), ovf[k], m_ovf[k]);
      chk($sformatf("k%0d clean_valid", k), cv[k], m_cv[k]);
      if (sz != 0) begin
        int head;
        head = mq[k][0];
        chk($sformatf("k%0d out_tag", k), otag[k], head >> 8);
        chk($sformatf("k%0d out_syndromes", k), osyn[k], head & 255);
        chk($sformatf("k%0d out_errors", k), oe[k], ((head & 255) != 0) ? 1 : 0);
      end
      if (m_cv[k]) chk($sformatf("k%0d clean_tag", k), ctag[k], m_ct[k]);
    end
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_step(input bit done, input logic [7:0] syn, input bit rdy);
    for (int k = 0; k < 2; k++) begin
      m_cv[k] = 0;
      if (rdy && mq[k].size() != 0) void'(mq[k].pop_front());
      if (done) begin
        if (k == 1 && syn == 8'd0) begin
          m_cv[k] = 1;
          m_ct[k] = m_tag[k];
        end else if (mq[k].size() < DEPTH) begin
          mq[k].push_back((m_tag[k] << 8) | int'(syn));
        end else begin
          m_ovf[k] = 1;
        end
        m_tag[k] = (m_tag[k] + 1) % 16;
      end
    end
  endtask

  // Check state at the falling edge, then drive the next inputs.
  task automatic cycle(input bit done, input logic [7:0] syn, input bit rdy);
    @(negedge clk);
    check_all();
    syn_done  = done;
    syndromes = syn;
    out_ready = rdy;
    model_step(done, syn, rdy);
  endtask

  task automatic async_reset();
    @(negedge clk);
    syn_done  = 1'b0;
    out_ready = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    reset_n = 1'b1;

    // Single write into an empty queue, then stall.
    cycle(1'b1, 8'h05, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    // Fill past capacity to force overflow.
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h22, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    // Reset with a full queue and overflow set.
    async_reset();
    cycle(1'b1, 8'h01, 1'b0);
    cycle(1'b1, 8'h02, 1'b0);
    // Full queue: push together with pop, then drain.
    cycle(1'b1, 8'h03, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);
    // Clean codeword followed by an erroneous one.
    cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b1, 8'h03, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    // Back-to-back stream through the tag wrap.
    async_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'(i + 1), 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 600; i++) begin
      int rp;
      logic [7:0] s;
      rp = 10 + (i / 100) * 16;
      s  = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      cycle($urandom_range(0, 3) != 0, s, $urandom_range(0, 99) < rp);
      if (i == 300) async_reset();
    end
    cycle(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check_all();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
